// File: rtl/saxi_lm_rd_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : saxi_lm_rd_bridge_if
// Description : Bundle of the SAXI read channels (AR/R) and the local-memory
//               read port used by saxi_lm_rd_bridge.
//               slave  : bridge side (accepts AR, produces R, issues lm_req)
//               master : environment side (AXI master + local memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface saxi_lm_rd_bridge_if #(
    parameter int AW    = 17,
    parameter int DW    = 64,
    parameter int IDW   = 6,
    parameter int LM_AW = 11
) ();
    // AR channel
    logic             arvalid;
    logic             arready;
    logic [IDW-1:0]   arid;
    logic [AW-1:0]    araddr;
    logic [7:0]       arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;

    // R channel
    logic             rvalid;
    logic             rready;
    logic [IDW-1:0]   rid;
    logic [DW-1:0]    rdata;
    logic [1:0]       rresp;
    logic             rlast;

    // Local memory read port
    logic             lm_req;
    logic             lm_sel;
    logic [LM_AW-1:0] lm_addr;
    logic             lm_gnt;
    logic             lm_rvalid;
    logic [DW-1:0]    lm_rdata;

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready,
        output lm_req, lm_sel, lm_addr,
        input  lm_gnt, lm_rvalid, lm_rdata
    );

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready,
        input  lm_req, lm_sel, lm_addr,
        output lm_gnt, lm_rvalid, lm_rdata
    );
endinterface
`default_nettype wire

// File: rtl/saxi_lm_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : saxi_lm_rd_bridge
// Description : AXI4 read-burst bridge from the SAXI port to the ILM/DLM.
//               Splits each burst into single-word local-memory reads,
//               decodes every beat against the ILM/DLM windows and returns
//               data through a 2-entry credit-managed response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module saxi_lm_rd_bridge #(
    parameter int            AW       = 17,
    parameter int            DW       = 64,
    parameter int            IDW      = 6,
    parameter logic [AW-1:0] ILM_BASE = 17'h0_0000,
    parameter logic [AW-1:0] DLM_BASE = 17'h1_0000,
    parameter int            LM_AW    = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    saxi_lm_rd_bridge_if.slave   bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BURST = 2'd1;
    localparam logic [1:0] c_ST_ERRB  = 2'd2;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    localparam logic [1:0] c_BURST_INCR = 2'b01;

    // Window size in bytes: one local memory of 2**LM_AW words of 8 bytes
    localparam logic [AW-1:0] c_WIN_BYTES = AW'(1) << (LM_AW + 3);

    // FIFO entry layout: {rdata, rresp, rlast}
    localparam int c_ENT_W = DW + 3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic               r_arready;
    logic [IDW-1:0]     r_id;
    logic [AW-1:0]      r_addr;
    logic [7:0]         r_len;
    logic [2:0]         r_size;
    logic [1:0]         r_burst;
    logic [7:0]         r_beat;
    logic               r_done;        // last beat of the burst already issued
    logic               r_inflight;    // memory read granted last cycle
    logic               r_infl_last;   // that read is the final beat
    logic [c_ENT_W-1:0] r_fifo [2];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_count;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic               w_ar_hs;
    logic               w_ar_bad;
    logic [AW-1:0]      w_off_ilm;
    logic [AW-1:0]      w_off_dlm;
    logic               w_hit_ilm;
    logic               w_hit_dlm;
    logic               w_hit;
    logic               w_last_beat;
    logic               w_pop;
    logic [2:0]         w_used;
    logic               w_credit;
    logic               w_lm_req;
    logic               w_gnt;
    logic               w_err_issue;
    logic               w_adv;
    logic [AW-1:0]      w_addr_nxt;
    logic               w_push_mem;
    logic               w_push;
    logic [c_ENT_W-1:0] w_push_ent;
    logic [c_ENT_W-1:0] w_head;
    logic               w_burst_end;
    logic [1:0]         w_state_nxt;
    logic [1:0]         w_err_resp;

    assign w_ar_hs  = bus.arvalid && r_arready;
    // WRAP, the reserved encoding and beats wider than the data path are refused
    assign w_ar_bad = bus.arburst[1] || (bus.arsize > 3'd3);

    // Window decode: subtracting the base lets one unsigned compare cover both
    // the lower and upper bound of each window. ILM wins if windows overlap.
    assign w_off_ilm = r_addr - ILM_BASE;
    assign w_off_dlm = r_addr - DLM_BASE;
    assign w_hit_ilm = (w_off_ilm < c_WIN_BYTES);
    assign w_hit_dlm = !w_hit_ilm && (w_off_dlm < c_WIN_BYTES);
    assign w_hit     = w_hit_ilm || w_hit_dlm;

    assign w_last_beat = (r_beat == r_len);

    assign w_pop = (r_count != 2'd0) && bus.rready;

    // Slots committed at the next edge. A pop this cycle frees a slot before
    // the data of a read granted now can land, so it is credited back; once a
    // request is raised its credit therefore survives until the grant.
    assign w_used   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_credit = (w_used < 3'd2);

    assign w_lm_req = (r_state == c_ST_BURST) && !r_done && w_credit && w_hit;
    assign w_gnt    = w_lm_req && bus.lm_gnt;

    // Error beats wait until no read is in flight so they cannot collide with
    // (or overtake) returning memory data in the FIFO.
    assign w_err_issue = (r_state != c_ST_IDLE) && !r_done && w_credit && !r_inflight
                         && ((r_state == c_ST_ERRB) || !w_hit);
    assign w_adv       = w_gnt || w_err_issue;
    assign w_err_resp  = (r_state == c_ST_ERRB) ? c_RESP_SLVERR : c_RESP_DECERR;

    assign w_addr_nxt = (r_burst == c_BURST_INCR) ? (r_addr + (AW'(1) << r_size)) : r_addr;

    // Stray lm_rvalid with nothing in flight (e.g. after reset) is ignored
    assign w_push_mem = bus.lm_rvalid && r_inflight;
    assign w_push     = w_push_mem || w_err_issue;
    assign w_push_ent = w_push_mem ? {bus.lm_rdata, c_RESP_OKAY, r_infl_last}
                                   : {{DW{1'b0}}, w_err_resp, w_last_beat};

    assign w_head      = r_fifo[r_rptr];
    assign w_burst_end = w_pop && w_head[0];

    // Next-state decode for the burst controller
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_ar_hs) begin
                    w_state_nxt = w_ar_bad ? c_ST_ERRB : c_ST_BURST;
                end
            end
            c_ST_BURST, c_ST_ERRB: begin
                if (w_burst_end) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register; arready is registered so it stays low through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_arready <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_arready <= (w_state_nxt == c_ST_IDLE);
        end
    end

    // Burst context: captured on AR, then beat counter/address step per issued beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            r_done  <= 1'b0;
        end else if (w_ar_hs) begin
            r_id    <= bus.arid;
            r_addr  <= bus.araddr;
            r_len   <= bus.arlen;
            r_size  <= bus.arsize;
            r_burst <= bus.arburst;
            r_beat  <= '0;
            r_done  <= 1'b0;
        end else if (w_adv) begin
            if (w_last_beat) begin
                r_done <= 1'b1;
            end else begin
                r_beat <= r_beat + 8'd1;
                r_addr <= w_addr_nxt;
            end
        end
    end

    // Track the single read whose data returns one cycle after its grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight  <= 1'b0;
            r_infl_last <= 1'b0;
        end else begin
            r_inflight  <= w_gnt;
            r_infl_last <= w_last_beat;
        end
    end

    // 2-entry response FIFO; push and pop may coincide even when full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo[i] <= '0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_push_ent;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.arready = r_arready;
    assign bus.rvalid  = (r_count != 2'd0);
    assign bus.rid     = r_id;
    assign bus.rdata   = bus.rvalid ? w_head[c_ENT_W-1:3] : {DW{1'b0}};
    assign bus.rresp   = bus.rvalid ? w_head[2:1] : 2'b00;
    assign bus.rlast   = bus.rvalid && w_head[0];

    assign bus.lm_req  = w_lm_req;
    assign bus.lm_sel  = w_lm_req && w_hit_dlm;
    assign bus.lm_addr = !w_lm_req ? {LM_AW{1'b0}}
                       : (w_hit_dlm ? w_off_dlm[LM_AW+2:3] : w_off_ilm[LM_AW+2:3]);

endmodule
`default_nettype wire

// File: tb/tb_saxi_lm_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_saxi_lm_rd_bridge
// Description : Directed self-checking bench for saxi_lm_rd_bridge with an
//               R-beat scoreboard, a local-memory request scoreboard and a
//               one-cycle-latency local memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_saxi_lm_rd_bridge;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  resp;
        logic        last;
        logic [5:0]  id;
    } rexp_t;

    logic clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    rexp_t       sb[$];
    logic [11:0] lm_q[$];

    logic        gnt_rand = 1'b0;
    logic        inject   = 1'b0;
    logic        pend     = 1'b0;
    logic [63:0] pend_data = '0;
    logic        prev_wait = 1'b0;
    logic        prev_sel  = 1'b0;
    logic [10:0] prev_addr = '0;
    int          g_cnt = 0;
    int          p_cnt = 0;
    int          max_out = 0;

    saxi_lm_rd_bridge_if #(.AW(17), .DW(64), .IDW(6), .LM_AW(11)) bus ();

    saxi_lm_rd_bridge #(
        .AW(17), .DW(64), .IDW(6),
        .ILM_BASE(17'h0_0000), .DLM_BASE(17'h1_0000), .LM_AW(11)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic sel, input logic [10:0] wa);
        return 64'hA5A5_A5A5_A5A5_A5A5 ^ {sel, 52'd0, wa};
    endfunction

    // Reference model of one burst: expected R beats and memory requests
    task automatic expect_burst(input logic [5:0] id, input logic [16:0] addr,
                                input logic [7:0] len, input logic [2:0] size,
                                input logic [1:0] burst);
        logic [16:0] a;
        logic [16:0] off;
        rexp_t       e;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            e.id   = id;
            e.last = (i == int'(len));
            off    = a - 17'h1_0000;
            if (burst[1] || size > 3'd3) begin
                e.d = '0; e.resp = 2'b10;
            end else if (a < 17'h0_4000) begin
                e.d = mem_word(1'b0, a[13:3]); e.resp = 2'b00;
                lm_q.push_back({1'b0, a[13:3]});
            end else if (a >= 17'h1_0000 && a < 17'h1_4000) begin
                e.d = mem_word(1'b1, off[13:3]); e.resp = 2'b00;
                lm_q.push_back({1'b1, off[13:3]});
            end else begin
                e.d = '0; e.resp = 2'b11;
            end
            sb.push_back(e);
            if (burst == 2'b01) a = a + (17'd1 << size);
        end
    endtask

    // Present an AR, wait (bounded) for acceptance; returns in cycle 1
    task automatic send_ar(input logic [5:0] id, input logic [16:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        int n;
        @(posedge clk); #1;
        bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr;
        bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        n = 0;
        @(negedge clk);
        while (bus.arready !== 1'b1 && n < 50) begin
            @(negedge clk); n++;
        end
        check("ar_accept_in_time", 64'(n < 50), 64'd1);
        expect_burst(id, addr, len, size, burst);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || lm_q.size() != 0 || bus.arready !== 1'b1) && n < 300) begin
            @(negedge clk); n++;
        end
        check(tag, 64'(n < 300), 64'd1);
    endtask

    // Local memory model: data one cycle after grant, optional random grant
    always @(posedge clk) begin
        #1;
        bus.lm_rvalid = pend | inject;
        bus.lm_rdata  = inject ? 64'hDEAD_BEEF_0BAD_F00D : pend_data;
        bus.lm_gnt    = gnt_rand ? (($urandom & 32'd1) != 32'd0) : 1'b1;
    end

    // Monitor: request stability, request/response scoreboards, occupancy
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            lm_q.delete();
            g_cnt = 0; p_cnt = 0;
            pend = 1'b0; prev_wait = 1'b0;
        end else begin
            if (prev_wait) begin
                check("lm_req_held", 64'(bus.lm_req), 64'd1);
                check("lm_sel_held", 64'(bus.lm_sel), 64'(prev_sel));
                check("lm_addr_held", 64'(bus.lm_addr), 64'(prev_addr));
            end
            prev_wait = bus.lm_req && !bus.lm_gnt;
            prev_sel  = bus.lm_sel;
            prev_addr = bus.lm_addr;
            pend = 1'b0;
            if (bus.lm_req && bus.lm_gnt) begin
                if (lm_q.size() == 0) begin
                    check("lm_req_expected", 64'(lm_q.size()), 64'd1);
                end else begin
                    check("lm_sel_addr", 64'({bus.lm_sel, bus.lm_addr}), 64'(lm_q.pop_front()));
                end
                pend = 1'b1;
                pend_data = mem_word(bus.lm_sel, bus.lm_addr);
                g_cnt++;
            end
            if (bus.rvalid && bus.rready) begin
                if (sb.size() == 0) begin
                    check("r_beat_expected", 64'(sb.size()), 64'd1);
                end else begin
                    rexp_t e;
                    e = sb.pop_front();
                    check("r_data", bus.rdata, e.d);
                    check("r_resp", 64'(bus.rresp), 64'(e.resp));
                    check("r_last", 64'(bus.rlast), 64'(e.last));
                    check("r_id", 64'(bus.rid), 64'(e.id));
                end
                p_cnt++;
            end
            if (g_cnt - p_cnt > max_out) max_out = g_cnt - p_cnt;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0;
        bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.rready = 1'b1;
        bus.lm_gnt = 1'b1; bus.lm_rvalid = 1'b0; bus.lm_rdata = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", 64'(bus.arready), 64'd0);
        check("rst_rvalid", 64'(bus.rvalid), 64'd0);
        check("rst_lm_req", 64'(bus.lm_req), 64'd0);
        check("rst_rid", 64'(bus.rid), 64'd0);
        check("rst_rdata", bus.rdata, 64'd0);
        check("rst_rresp_rlast", 64'({bus.rresp, bus.rlast}), 64'd0);
        check("rst_lm_sel_addr", 64'({bus.lm_sel, bus.lm_addr}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("arready_before_first_clk", 64'(bus.arready), 64'd0);
        @(negedge clk);
        check("arready_after_release", 64'(bus.arready), 64'd1);

        // Single beat, ILM, latency
        send_ar(6'd5, 17'h0_0008, 8'd0, 3'd3, 2'b01);
        @(negedge clk);
        check("single_lm_req_c1", 64'(bus.lm_req), 64'd1);
        check("single_lm_sel", 64'(bus.lm_sel), 64'd0);
        check("single_lm_addr", 64'(bus.lm_addr), 64'd1);
        check("single_arready_low", 64'(bus.arready), 64'd0);
        @(negedge clk);
        check("single_rvalid_c2", 64'(bus.rvalid), 64'd0);
        @(negedge clk);
        check("single_rvalid_c3", 64'(bus.rvalid), 64'd1);
        wait_drain("single_drain");

        // INCR burst into DLM, back-to-back requests
        send_ar(6'd9, 17'h1_0000, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("dlm_lm_req", 64'(bus.lm_req), 64'd1);
            check("dlm_lm_sel", 64'(bus.lm_sel), 64'd1);
            check("dlm_lm_addr", 64'(bus.lm_addr), 64'(i));
        end
        wait_drain("dlm_drain");

        // Backpressure: rready low for 5 cycles after first rvalid
        max_out = 0;
        send_ar(6'd10, 17'h1_0000, 8'd3, 3'd3, 2'b01);
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        check("bp_first_rvalid", 64'(bus.rvalid), 64'd1);
        @(posedge clk); #1;
        bus.rready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_no_req_when_full", 64'(bus.lm_req), 64'd0);
        check("bp_rvalid_held", 64'(bus.rvalid), 64'd1);
        @(posedge clk); #1;
        bus.rready = 1'b1;
        wait_drain("bp_drain");
        check("bp_outstanding_le_2", 64'(max_out <= 2), 64'd1);

        // Window exit: second beat leaves ILM
        send_ar(6'd3, 17'h0_3FF8, 8'd1, 3'd3, 2'b01);
        @(negedge clk);
        check("wexit_lm_addr", 64'({bus.lm_sel, bus.lm_addr}), 64'h7FF);
        wait_drain("wexit_drain");

        // Illegal bursts: WRAP, reserved burst type, oversized beat
        send_ar(6'd7, 17'h0_0100, 8'd2, 3'd3, 2'b10);
        wait_drain("wrap_drain");
        send_ar(6'd8, 17'h0_0100, 8'd0, 3'd3, 2'b11);
        wait_drain("rsvd_drain");
        send_ar(6'd13, 17'h0_0000, 8'd1, 3'd4, 2'b01);
        wait_drain("size_drain");

        // FIXED burst and sub-word INCR
        send_ar(6'd11, 17'h1_0010, 8'd2, 3'd3, 2'b00);
        wait_drain("fixed_drain");
        send_ar(6'd12, 17'h0_0004, 8'd3, 3'd2, 2'b01);
        wait_drain("subword_drain");

        // Random grant stalls; request must hold until granted
        gnt_rand = 1'b1;
        send_ar(6'd14, 17'h0_0100, 8'd7, 3'd3, 2'b01);
        wait_drain("rgnt_drain");
        gnt_rand = 1'b0;

        // Reset in the middle of an 8-beat burst
        send_ar(6'd20, 17'h1_0000, 8'd7, 3'd3, 2'b01);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", 64'(bus.rvalid), 64'd0);
        check("mid_rst_lm_req", 64'(bus.lm_req), 64'd0);
        check("mid_rst_arready", 64'(bus.arready), 64'd0);
        check("mid_rst_rid", 64'(bus.rid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        inject = 1'b1;
        check("post_rst_arready_low", 64'(bus.arready), 64'd0);
        @(negedge clk);
        inject = 1'b0;
        check("post_rst_arready_high", 64'(bus.arready), 64'd1);
        repeat (4) @(negedge clk);
        check("post_rst_no_stale_r", 64'(bus.rvalid), 64'd0);

        // Recovery burst after reset
        send_ar(6'd21, 17'h0_0020, 8'd0, 3'd3, 2'b01);
        wait_drain("recover_drain");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
